// File: rtl/count_seq_pkg.sv
// Shared types and constants for the step-counter / sync-pulse sequencer.
package count_seq_pkg;

    localparam int CNT_W  = 16;
    localparam int STEP_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_DRAIN = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic [STEP_W-1:0] step;
        logic [CNT_W-1:0]  thresh;
    } seq_cfg_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the DELAY, PULSE and DRAIN phases.
module seq_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic [W-1:0] count_o,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    // Counts down to zero and parks there until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count_o  = cnt_q;
    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencer: step counter to threshold, delayed sync pulse, drain period, done strobe.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int STEP_W       = 3,
    parameter int DEF_STEP     = 2,
    parameter int DEF_THRESH   = 16,
    parameter int PULSE_DELAY  = 2,
    parameter int PULSE_WIDTH  = 1,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we_i,
    input  logic [STEP_W-1:0] cfg_step_i,
    input  logic [WIDTH-1:0]  cfg_thresh_i,
    output logic              cfg_err_o,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [WIDTH-1:0]  count_o,
    output logic              busy_o,
    output logic              thr_hit_o,
    output logic              sync_pulse_o,
    output logic              done_o,
    output logic              miss_o
);

    localparam int TMR_W = $clog2(max3(PULSE_DELAY, PULSE_WIDTH, DRAIN_CYCLES) + 1);

    seq_state_e       state_q, state_d;
    seq_cfg_t         cfg_q, cfg_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             miss_q, miss_d;
    logic             done_q, done_d;
    logic             thr_hit_q, thr_hit_d;
    logic             sync_q, sync_d;
    logic             busy_q, busy_d;
    logic             cfg_err_q, cfg_err_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic [TMR_W-1:0] tmr_count;
    logic             tmr_expire;
    logic [WIDTH:0]   sum_wide;

    seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (tmr_load),
        .value_i  (tmr_value),
        .count_o  (tmr_count),
        .expire_o (tmr_expire)
    );

    // One extra bit so an overshoot past 2^WIDTH-1 still compares as "above threshold".
    assign sum_wide = {1'b0, count_q} + {{(WIDTH + 1 - STEP_W){1'b0}}, cfg_q.step};

    always_comb begin
        cfg_d     = cfg_q;
        cfg_err_d = 1'b0;
        if (cfg_we_i) begin
            if (state_q == ST_IDLE && cfg_step_i != '0) begin
                cfg_d.step   = cfg_step_i;
                cfg_d.thresh = cfg_thresh_i;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        state_d   = state_q;
        count_d   = count_q;
        miss_d    = miss_q;
        done_d    = 1'b0;
        thr_hit_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;

        // The hit is detected on the value being loaded so thr_hit lines up with count showing thresh.
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    count_d = '0;
                    miss_d  = 1'b0;
                    if (cfg_d.thresh == '0) begin
                        thr_hit_d = 1'b1;
                        state_d   = ST_DELAY;
                        tmr_load  = 1'b1;
                        tmr_value = TMR_W'(PULSE_DELAY - 1);
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                if (sum_wide == {1'b0, cfg_q.thresh}) begin
                    count_d   = sum_wide[WIDTH-1:0];
                    thr_hit_d = 1'b1;
                    state_d   = ST_DELAY;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(PULSE_DELAY - 1);
                end else if (sum_wide > {1'b0, cfg_q.thresh}) begin
                    miss_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    count_d = sum_wide[WIDTH-1:0];
                end
            end
            ST_DELAY: begin
                count_d = sum_wide[WIDTH-1:0];
                if (tmr_expire) begin
                    state_d   = ST_PULSE;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(PULSE_WIDTH - 1);
                end
            end
            ST_PULSE: begin
                count_d = sum_wide[WIDTH-1:0];
                if (tmr_expire) begin
                    state_d   = ST_DRAIN;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                // DRAIN spans DRAIN_CYCLES+1 cycles; done is raised on the last one.
                count_d = sum_wide[WIDTH-1:0];
                if (tmr_count == TMR_W'(1)) begin
                    done_d = 1'b1;
                end
                if (tmr_expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_i) begin
            state_d   = ST_IDLE;
            count_d   = count_q;
            miss_d    = miss_q;
            done_d    = 1'b0;
            thr_hit_d = 1'b0;
            tmr_load  = 1'b0;
        end

        sync_d = (state_d == ST_PULSE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cfg_q.step  <= STEP_W'(DEF_STEP);
            cfg_q.thresh <= WIDTH'(DEF_THRESH);
            count_q     <= '0;
            miss_q      <= 1'b0;
            done_q      <= 1'b0;
            thr_hit_q   <= 1'b0;
            sync_q      <= 1'b0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            count_q     <= count_d;
            miss_q      <= miss_d;
            done_q      <= done_d;
            thr_hit_q   <= thr_hit_d;
            sync_q      <= sync_d;
            busy_q      <= busy_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign count_o      = count_q;
    assign busy_o       = busy_q;
    assign thr_hit_o    = thr_hit_q;
    assign sync_pulse_o = sync_q;
    assign done_o       = done_q;
    assign miss_o       = miss_q;
    assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed self-checking bench for count_seq_ctrl with hand-computed expected values.
`timescale 1ns/1ps
module tb_count_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we_i;
    logic [2:0]  cfg_step_i;
    logic [15:0] cfg_thresh_i;
    logic        cfg_err_o;
    logic        start_i;
    logic        abort_i;
    logic [15:0] count_o;
    logic        busy_o;
    logic        thr_hit_o;
    logic        sync_pulse_o;
    logic        done_o;
    logic        miss_o;

    int checksTotal  = 0;
    int checksPassed = 0;
    logic sawHit, sawPulse, sawDone;

    count_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we_i     (cfg_we_i),
        .cfg_step_i   (cfg_step_i),
        .cfg_thresh_i (cfg_thresh_i),
        .cfg_err_o    (cfg_err_o),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .count_o      (count_o),
        .busy_o       (busy_o),
        .thr_hit_o    (thr_hit_o),
        .sync_pulse_o (sync_pulse_o),
        .done_o       (done_o),
        .miss_o       (miss_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives one cycle of inputs, advances past the edge, then returns inputs to idle.
    task automatic applyStimulus(input logic we, input logic [2:0] step, input logic [15:0] thr,
                                 input logic st, input logic ab);
        cfg_we_i     = we;
        cfg_step_i   = step;
        cfg_thresh_i = thr;
        start_i      = st;
        abort_i      = ab;
        tick();
        cfg_we_i = 1'b0;
        start_i  = 1'b0;
        abort_i  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checksTotal++;
        if (got === exp) checksPassed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " count"}, 32'(count_o), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy_o), 32'd0);
        checkOutput({tag, " thr_hit"}, 32'(thr_hit_o), 32'd0);
        checkOutput({tag, " sync"}, 32'(sync_pulse_o), 32'd0);
        checkOutput({tag, " done"}, 32'(done_o), 32'd0);
        checkOutput({tag, " miss"}, 32'(miss_o), 32'd0);
        checkOutput({tag, " cfg_err"}, 32'(cfg_err_o), 32'd0);
    endtask

    initial begin
        reset = 1'b1; cfg_we_i = 1'b0; cfg_step_i = '0; cfg_thresh_i = '0;
        start_i = 1'b0; abort_i = 1'b0;
        idleCycles(2);
        reset = 1'b0;
        checkAllZero("reset");

        $display("[TB] test 1: defaults step 2 thr 16");
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            checkOutput($sformatf("t1 count S+%0d", k), 32'(count_o), 32'(2 * (k - 1)));
            checkOutput($sformatf("t1 thr_hit S+%0d", k), 32'(thr_hit_o), 32'(k == 9));
            checkOutput($sformatf("t1 sync S+%0d", k), 32'(sync_pulse_o), 32'(k == 11));
            checkOutput($sformatf("t1 done S+%0d", k), 32'(done_o), 32'(k == 16));
            checkOutput($sformatf("t1 busy S+%0d", k), 32'(busy_o), 32'(k <= 16));
            tick();
        end
        checkOutput("t1 count holds", 32'(count_o), 32'd32);

        $display("[TB] test 2: step 3 thr 16 overshoot");
        applyStimulus(1'b1, 3'd3, 16'd16, 1'b0, 1'b0);
        checkOutput("t2 cfg_err", 32'(cfg_err_o), 32'd0);
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            checkOutput($sformatf("t2 count S+%0d", k), 32'(count_o), (k <= 6) ? 32'(3 * (k - 1)) : 32'd15);
            checkOutput($sformatf("t2 miss S+%0d", k), 32'(miss_o), 32'(k == 7));
            checkOutput($sformatf("t2 done S+%0d", k), 32'(done_o), 32'(k == 7));
            checkOutput($sformatf("t2 sync S+%0d", k), 32'(sync_pulse_o), 32'd0);
            checkOutput($sformatf("t2 busy S+%0d", k), 32'(busy_o), 32'(k <= 6));
            tick();
        end
        checkOutput("t2 count holds", 32'(count_o), 32'd15);
        checkOutput("t2 miss sticky", 32'(miss_o), 32'd1);

        $display("[TB] test 3: thr 0xFFFF wide compare, cfg and start together");
        applyStimulus(1'b1, 3'd2, 16'hFFFF, 1'b1, 1'b0);
        checkOutput("t3 count S+1", 32'(count_o), 32'd0);
        checkOutput("t3 miss cleared", 32'(miss_o), 32'd0);
        checkOutput("t3 busy S+1", 32'(busy_o), 32'd1);
        sawHit = 1'b0; sawPulse = 1'b0;
        for (int i = 0; i < 32767; i++) begin
            tick();
            sawHit   = sawHit | thr_hit_o;
            sawPulse = sawPulse | sync_pulse_o;
        end
        checkOutput("t3 count top", 32'(count_o), 32'hFFFE);
        checkOutput("t3 miss early", 32'(miss_o), 32'd0);
        tick();
        checkOutput("t3 miss", 32'(miss_o), 32'd1);
        checkOutput("t3 done", 32'(done_o), 32'd1);
        checkOutput("t3 count after miss", 32'(count_o), 32'hFFFE);
        checkOutput("t3 busy after miss", 32'(busy_o), 32'd0);
        checkOutput("t3 no wrap hit", 32'(sawHit | thr_hit_o), 32'd0);
        checkOutput("t3 no pulse", 32'(sawPulse), 32'd0);

        applyStimulus(1'b1, 3'd2, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        checkOutput("t3 thr0 hit S+1", 32'(thr_hit_o), 32'd1);
        checkOutput("t3 thr0 count S+1", 32'(count_o), 32'd0);
        idleCycles(2);
        checkOutput("t3 thr0 sync S+3", 32'(sync_pulse_o), 32'd1);
        idleCycles(5);
        checkOutput("t3 thr0 done S+8", 32'(done_o), 32'd1);
        tick();
        checkOutput("t3 thr0 idle S+9", 32'(busy_o), 32'd0);

        $display("[TB] test 4: config rejection");
        applyStimulus(1'b1, 3'd0, 16'd5, 1'b0, 1'b0);
        checkOutput("t4 step0 cfg_err", 32'(cfg_err_o), 32'd1);
        tick();
        checkOutput("t4 cfg_err one cycle", 32'(cfg_err_o), 32'd0);
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        checkOutput("t4 thresh kept", 32'(thr_hit_o), 32'd1);
        applyStimulus(1'b1, 3'd5, 16'd3, 1'b0, 1'b0);
        checkOutput("t4 busy cfg_err", 32'(cfg_err_o), 32'd1);
        checkOutput("t4 step kept", 32'(count_o), 32'd2);
        tick();
        checkOutput("t4 run sync S+3", 32'(sync_pulse_o), 32'd1);
        checkOutput("t4 run count S+3", 32'(count_o), 32'd4);
        idleCycles(5);
        checkOutput("t4 run done S+8", 32'(done_o), 32'd1);
        tick();

        $display("[TB] test 5: abort during sync pulse");
        applyStimulus(1'b1, 3'd1, 16'd6, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        idleCycles(8);
        checkOutput("t5 sync S+9", 32'(sync_pulse_o), 32'd1);
        checkOutput("t5 count S+9", 32'(count_o), 32'd8);
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
        checkOutput("t5 sync dropped", 32'(sync_pulse_o), 32'd0);
        checkOutput("t5 idle after abort", 32'(busy_o), 32'd0);
        checkOutput("t5 count holds", 32'(count_o), 32'd8);
        sawDone = done_o;
        for (int i = 0; i < 8; i++) begin
            tick();
            sawDone = sawDone | done_o;
        end
        checkOutput("t5 no done", 32'(sawDone), 32'd0);
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        checkOutput("t5 restart count", 32'(count_o), 32'd0);
        idleCycles(6);
        checkOutput("t5 restart hit S+7", 32'(thr_hit_o), 32'd1);
        checkOutput("t5 restart count S+7", 32'(count_o), 32'd6);

        $display("[TB] test 6: start ignored while busy, reset in DRAIN");
        idleCycles(4);
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        checkOutput("t6 start ignored busy", 32'(busy_o), 32'd1);
        checkOutput("t6 start ignored count", 32'(count_o), 32'd11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkAllZero("t6 reset");
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        tick();
        checkOutput("t6 default step", 32'(count_o), 32'd2);
        idleCycles(7);
        checkOutput("t6 default thr hit", 32'(thr_hit_o), 32'd1);
        checkOutput("t6 default thr count", 32'(count_o), 32'd16);
        idleCycles(8);
        checkOutput("t6 final idle", 32'(busy_o), 32'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
